// File: rtl/tube_scan_sequencer.sv
// Scan timing master for a 4-digit 7-segment tube display with a double-buffered CPU write port.
// Optional frame-rate dimming is enabled by defining TUBE_DIM_EN, which adds the brightness port.
module tube_scan_sequencer #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned BLANK    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrValid,
  output logic        wrReady,
  input  logic [15:0] wrData,
  input  logic [3:0]  wrDots,
  input  logic [3:0]  wrAuxs,
`ifdef TUBE_DIM_EN
  input  logic [3:0]  brightness,
`endif
  output logic [1:0]  dig,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3,
  output logic [3:0]  dig4,
  output logic [3:0]  dots,
  output logic [3:0]  auxs,
  output logic        blank,
  output logic        frameStart
);

  localparam int unsigned   CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    dig_nxt;
  logic          at_last, boundary, accept, blank_nxt;
  logic          pending;
  logic [15:0]   sh_data;
  logic [3:0]    sh_dots, sh_auxs;

  // A full shadow buffer is exactly the not-ready condition, so no separate flag is kept.
  assign wrReady = ~pending;

  always_comb begin
    at_last  = (cnt == LAST);
    boundary = at_last && (dig == 2'd3);
    cnt_nxt  = at_last ? '0 : cnt + 1'b1;
    dig_nxt  = at_last ? dig + 2'd1 : dig;
    accept   = wrValid && ~pending;
  end

`ifdef TUBE_DIM_EN
  logic [3:0] fc, fc_nxt, bright, bright_nxt;

  always_comb begin
    fc_nxt     = boundary ? fc + 4'd1 : fc;
    bright_nxt = boundary ? brightness : bright;
    blank_nxt  = (32'(cnt_nxt) < BLANK) || (fc_nxt > bright_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc     <= 4'd0;
      bright <= 4'hF;
    end else begin
      fc     <= fc_nxt;
      bright <= bright_nxt;
    end
  end
`else
  always_comb begin
    blank_nxt = (32'(cnt_nxt) < BLANK);
  end
`endif

  // Scan timing: blank and frameStart are registered from the next-state values so they line up with cnt/dig.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      dig        <= 2'd0;
      blank      <= 1'b1;
      frameStart <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      dig        <= dig_nxt;
      blank      <= blank_nxt;
      frameStart <= (cnt_nxt == '0) && (dig_nxt == 2'd0);
    end
  end

  // Shadow capture and frame-boundary transfer; accept and transfer are exclusive because accept needs !pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      sh_data <= 16'h0000;
      sh_dots <= 4'h0;
      sh_auxs <= 4'h0;
      dig1    <= 4'h0;
      dig2    <= 4'h0;
      dig3    <= 4'h0;
      dig4    <= 4'h0;
      dots    <= 4'h0;
      auxs    <= 4'hF;
    end else if (accept) begin
      pending <= 1'b1;
      sh_data <= wrData;
      sh_dots <= wrDots;
      sh_auxs <= wrAuxs;
    end else if (boundary && pending) begin
      pending <= 1'b0;
      dig1    <= sh_data[3:0];
      dig2    <= sh_data[7:4];
      dig3    <= sh_data[11:8];
      dig4    <= sh_data[15:12];
      dots    <= sh_dots;
      auxs    <= sh_auxs;
    end
  end

endmodule

// File: tb/tb_tube_scan_sequencer.sv
// Directed bench for tube_scan_sequencer with PRESCALE=8, BLANK=2 (32-clock frames).
module tb_tube_scan_sequencer;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = 4 * PRESCALE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrValid = 1'b0;
  logic [15:0] wrData = 16'h0000;
  logic [3:0]  wrDots = 4'h0;
  logic [3:0]  wrAuxs = 4'h0;
`ifdef TUBE_DIM_EN
  logic [3:0]  brightness = 4'hF;
`endif
  logic        wrReady, blank, frameStart;
  logic [1:0]  dig;
  logic [3:0]  dig1, dig2, dig3, dig4, dots, auxs;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  wire [23:0] active = {dig4, dig3, dig2, dig1, dots, auxs};
  wire [28:0] snap   = {dig, blank, frameStart, wrReady, dig4, dig3, dig2, dig1, dots, auxs};
  localparam logic [28:0] SNAP_RST = {2'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'h0, 4'hF};

  always #5 clk = ~clk;

  tube_scan_sequencer #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .wrValid(wrValid), .wrReady(wrReady),
    .wrData(wrData), .wrDots(wrDots), .wrAuxs(wrAuxs),
`ifdef TUBE_DIM_EN
    .brightness(brightness),
`endif
    .dig(dig), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .dots(dots), .auxs(auxs), .blank(blank), .frameStart(frameStart)
  );

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic logic [1:0] exp_dig(int c);
    return 2'((c / PRESCALE) % 4);
  endfunction

  function automatic logic exp_blank(int c);
    return (c % PRESCALE) < BLANK;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (snap !== SNAP_RST) begin
      miscompares++;
      $display("FAIL reset_held: got %h expected %h", snap, SNAP_RST);
    end
    rst_n = 1'b1;
    k = 0;
    #1;
    vectors++;
    if (snap !== SNAP_RST) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", snap, SNAP_RST);
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 80; i++) begin
      step();
      vectors++;
      if (dig !== exp_dig(k)) begin
        miscompares++;
        $display("FAIL free_dig k=%0d: got %0d expected %0d", k, dig, exp_dig(k));
      end
      vectors++;
      if (blank !== exp_blank(k)) begin
        miscompares++;
        $display("FAIL free_blank k=%0d: got %b expected %b", k, blank, exp_blank(k));
      end
      vectors++;
      if (frameStart !== (k % FRAME == 0)) begin
        miscompares++;
        $display("FAIL free_frameStart k=%0d: got %b expected %b", k, frameStart, (k % FRAME == 0));
      end
      vectors++;
      if (active !== 24'h00000F) begin
        miscompares++;
        $display("FAIL free_active k=%0d: got %h expected 00000F", k, active);
      end
    end
  endtask

  task automatic test_write();
    while (k % FRAME != PRESCALE) step();
    vectors++;
    if (dig !== 2'd1 || wrReady !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_pre: dig=%0d wrReady=%b expected dig=1 wrReady=1", dig, wrReady);
    end
    wrValid = 1'b1; wrData = 16'h4321; wrDots = 4'b0001; wrAuxs = 4'h0;
    step();
    wrValid = 1'b0; wrData = 16'hFFFF; wrDots = 4'hF; wrAuxs = 4'hF;
    vectors++;
    if (wrReady !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_ready_drop: got %b expected 0", wrReady);
    end
    do begin
      vectors++;
      if (active !== 24'h00000F || wrReady !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_hold k=%0d: active %h ready %b expected 00000F ready 0", k, active, wrReady);
      end
      step();
    end while (k % FRAME != 0);
    vectors++;
    if (active !== 24'h432110) begin
      miscompares++;
      $display("FAIL wr_show: got %h expected 432110", active);
    end
    vectors++;
    if (dig !== 2'd0 || wrReady !== 1'b1 || frameStart !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_boundary: dig=%0d ready=%b fs=%b expected 0 1 1", dig, wrReady, frameStart);
    end
  endtask

  task automatic test_back_to_back();
    wrValid = 1'b1; wrData = 16'hAAAA; wrDots = 4'hA; wrAuxs = 4'h5;
    step();
    wrData = 16'h5555; wrDots = 4'h5; wrAuxs = 4'hA;
    vectors++;
    if (wrReady !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ready_drop: got %b expected 0", wrReady);
    end
    do begin
      vectors++;
      if (active !== 24'h432110 || wrReady !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_hold1 k=%0d: active %h ready %b expected 432110 ready 0", k, active, wrReady);
      end
      step();
    end while (k % FRAME != 0);
    vectors++;
    if (active !== 24'hAAAAA5 || wrReady !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: active %h ready %b expected AAAAA5 ready 1", active, wrReady);
    end
    step();
    wrValid = 1'b0; wrData = 16'h0000; wrDots = 4'h0; wrAuxs = 4'h0;
    vectors++;
    if (wrReady !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second_accept: ready got %b expected 0", wrReady);
    end
    do begin
      vectors++;
      if (active !== 24'hAAAAA5) begin
        miscompares++;
        $display("FAIL b2b_hold2 k=%0d: got %h expected AAAAA5", k, active);
      end
      step();
    end while (k % FRAME != 0);
    vectors++;
    if (active !== 24'h55555A || wrReady !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: active %h ready %b expected 55555A ready 1", active, wrReady);
    end
  endtask

  task automatic test_reset_pending();
    repeat (3) step();
    wrValid = 1'b1; wrData = 16'h9876; wrDots = 4'h6; wrAuxs = 4'h0;
    step();
    wrValid = 1'b0;
    vectors++;
    if (wrReady !== 1'b0) begin
      miscompares++;
      $display("FAIL rp_pending: ready got %b expected 0", wrReady);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (snap !== SNAP_RST) begin
      miscompares++;
      $display("FAIL rp_async: got %h expected %h", snap, SNAP_RST);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    vectors++;
    if (snap !== SNAP_RST) begin
      miscompares++;
      $display("FAIL rp_release: got %h expected %h", snap, SNAP_RST);
    end
    for (int i = 0; i < 70; i++) begin
      step();
      vectors++;
      if (active !== 24'h00000F || wrReady !== 1'b1) begin
        miscompares++;
        $display("FAIL rp_dark k=%0d: active %h ready %b expected 00000F ready 1", k, active, wrReady);
      end
      vectors++;
      if (dig !== exp_dig(k) || frameStart !== (k % FRAME == 0)) begin
        miscompares++;
        $display("FAIL rp_scan k=%0d: dig %0d fs %b expected %0d %b", k, dig, frameStart, exp_dig(k), (k % FRAME == 0));
      end
    end
  endtask

  task automatic test_boundary_write();
    while (k % FRAME != FRAME - 1) step();
    wrValid = 1'b1; wrData = 16'hBEEF; wrDots = 4'hC; wrAuxs = 4'h3;
    step();
    wrValid = 1'b0;
    vectors++;
    if (wrReady !== 1'b0 || dig !== 2'd0) begin
      miscompares++;
      $display("FAIL bw_accept: ready %b dig %0d expected 0 0", wrReady, dig);
    end
    do begin
      vectors++;
      if (active !== 24'h00000F) begin
        miscompares++;
        $display("FAIL bw_hold k=%0d: got %h expected 00000F", k, active);
      end
      step();
    end while (k % FRAME != 0);
    vectors++;
    if (active !== 24'hBEEFC3 || wrReady !== 1'b1) begin
      miscompares++;
      $display("FAIL bw_show: active %h ready %b expected BEEFC3 ready 1", active, wrReady);
    end
  endtask

`ifdef TUBE_DIM_EN
  task automatic test_dim();
    logic lit;
    rst_n = 1'b0;
    brightness = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    for (int f = 0; f < 32; f++) begin
      if (f == 16) brightness = 4'd15;
      lit = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
        if (!blank) lit = 1'b1;
        if (f >= 16) begin
          vectors++;
          if (blank !== exp_blank(k)) begin
            miscompares++;
            $display("FAIL dim_full_blank k=%0d: got %b expected %b", k, blank, exp_blank(k));
          end
        end
        step();
      end
      vectors++;
      if (lit !== ((f % 16) <= 3 || f >= 16)) begin
        miscompares++;
        $display("FAIL dim_frame f=%0d: lit %b expected %b", f, lit, ((f % 16) <= 3 || f >= 16));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_write();
    test_back_to_back();
    test_reset_pending();
    test_boundary_write();
`ifdef TUBE_DIM_EN
    test_dim();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
